bip_result_reporter: RTL and testbench
======================================

# bip_result_reporter

Parametrised UART-side host interface for the BIP processor. Parses a start command from the UART receiver, drives the processor run enable, and when the program finishes streams every result channel back as an ASCII line (`<label>:<value>` CR LF). Sits between the UART RX/TX cores and the BIP top level, generalising the fixed two-value (accumulator, cycle count) report to N channels of any width.

## Interface
- DATA_W, 16, width of each result channel (4..32)
- N_CH, 2, number of result channels (1..8); channel i label is ASCII 'A'+i
- DIG_N, ((DATA_W*1233)>>12)+1, max decimal digits per channel (derived, not overridden)
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- rx_done_tick  in  1  one-cycle pulse: rx_data valid
- rx_data  in  8  received byte
- tx_done_tick  in  1  one-cycle pulse: UART TX finished current byte
- done  in  1  BIP program finished (level)
- results  in  N_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- run  out  1  BIP enable; reset 0
- tx_start  out  1  one-cycle pulse, loads tx_data into UART TX; reset 0
- tx_data  out  8  byte to transmit; reset 0
- busy  out  1  high from command accept until last LF done; reset 0

## Operation
- States: IDLE, GOT_S, RUN, LATCH, CONV, LABEL, COLON, DIGIT, CR, LF.
- IDLE: on rx_done_tick with rx_data=0x73 ('s') -> GOT_S; any other byte stays IDLE.
- GOT_S: next rx_done_tick with 0x0D -> RUN, assert run and busy; 0x73 -> stay GOT_S; anything else -> IDLE.
- RUN: rx bytes ignored. When done=1 -> LATCH: copy results to internal shadow register, deassert run, channel index ch=0.
- CONV: binary-to-BCD of shadow channel ch (sequential double-dabble, DIG_N BCD nibbles); then LABEL.
- LABEL/COLON/DIGIT/CR/LF: each state issues one byte: 'A'+ch, 0x3A, digits, 0x0D, 0x0A.
- DIGIT: leading-zero suppression; value 0 sends exactly one '0'. Digit byte = nibble + 0x30, most significant first.
- After LF: ch<N_CH-1 -> ch+1, CONV; else -> IDLE, busy=0.
- Result values changing after LATCH have no effect on the report.
- rx bytes arriving from RUN through LF are dropped; command parser restarts in IDLE.
- reset at any time: all state, shadow, outputs to reset values; partial line abandoned.

## Timing
- Command accept: run rises the cycle after the rx_done_tick carrying 0x0D.
- done sampled only in RUN; run falls the cycle after done is first seen high.
- CONV latency: exactly DATA_W cycles per channel.
- Byte handshake: tx_data set and tx_start pulsed in the same cycle on state entry; tx_data held stable until tx_done_tick; next tx_start no earlier than the cycle after tx_done_tick. Never two tx_start without an intervening tx_done_tick.
- tx_done_tick outside a byte-wait is ignored.
- Simultaneous rx_done_tick and tx_done_tick: both honoured per rules above (rx dropped if busy).

## Configuration
- REPORT_HEX_EN: defined -> values sent as fixed-width uppercase hex, ceil(DATA_W/4) digits, no zero suppression, CONV state and BCD converter removed (LABEL follows LATCH/LF directly). Undefined -> decimal with zero suppression as above.

## Structure
- Package bip_report_pkg: state enum, ASCII constants (CHAR_S, CHAR_CR, CHAR_LF, CHAR_COLON, CHAR_0, CHAR_A), DIG_N function.
- Sub-module bip_bin2bcd: start/busy/done sequential double-dabble, parameter DATA_W, output DIG_N*4 bits.

## Test plan
- Send 's', CR; done=1 with A=0x00FF, B=0x0000 -> run 1 then 0; bytes "A:255\r\nB:0\r\n", busy falls after final LF.
- Send 'x', CR, then 's','q',CR -> run stays 0; then 's','s',CR -> run rises.
- DATA_W=32, N_CH=3, values 4294967295, 10, 1000000000 -> "A:4294967295\r\nB:10\r\nC:1000000000\r\n"; CONV 32 cycles each.
- Change results after LATCH, send 's',CR mid-report -> report uses latched values, command ignored, no extra run.
- Assert reset mid-DIGIT of channel B -> tx_start, run, busy, tx_data 0 next cycle; new 's',CR works.
- REPORT_HEX_EN, DATA_W=16, A=0x00AB -> "A:00AB\r\n".

Source files
------------

// File: rtl/bip_report_pkg.sv
// Shared types and constants for the BIP UART result reporter.
// State encoding, ASCII byte constants and the decimal digit-count helper.
package bip_report_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_GOT_S = 4'd1,
        ST_RUN   = 4'd2,
        ST_LATCH = 4'd3,
        ST_CONV  = 4'd4,
        ST_LABEL = 4'd5,
        ST_COLON = 4'd6,
        ST_DIGIT = 4'd7,
        ST_CR    = 4'd8,
        ST_LF    = 4'd9
    } state_t;

    localparam logic [7:0] CHAR_S     = 8'h73;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_A     = 8'h41;

    // Decimal digits needed for a w-bit unsigned value (1233/4096 ~ log10(2)).
    function automatic int dig_n(input int w);
        return ((w * 1233) >> 12) + 1;
    endfunction

    // Nibble to ASCII; decimal nibbles never exceed 9, so one helper serves both modes.
    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        if (n < 4'd10) return CHAR_0 + {4'd0, n};
        else           return CHAR_A + {4'd0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/bip_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// The first shift happens on the start edge, so the result is ready and done
// pulses exactly DATA_W cycles after start.
module bip_bin2bcd
    import bip_report_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [DATA_W-1:0]           bin_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [dig_n(DATA_W)*4-1:0]  bcd_o
);

    localparam int DIG_N = dig_n(DATA_W);
    localparam int BCD_W = DIG_N * 4;

    logic [DATA_W-1:0] sh_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  adj;
    logic [5:0]        cnt_q;
    logic              busy_q;
    logic              done_q;

    // Add-3 correction on every BCD nibble >= 5 before the next shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIG_N; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // Shift engine: load with first shift applied, then DATA_W-1 adjusted shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                sh_q   <= bin_i << 1;
                bcd_q  <= BCD_W'(bin_i[DATA_W-1]);
                cnt_q  <= 6'(DATA_W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sh_q  <= sh_q << 1;
                bcd_q <= {adj[BCD_W-2:0], sh_q[DATA_W-1]};
                cnt_q <= cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/bip_result_reporter.sv
// UART-side host interface for the BIP processor.
// Parses "s" CR, runs the processor, then reports each channel as
// "<label>:<value>" CR LF. Define REPORT_HEX_EN for fixed-width uppercase hex
// output (no converter, no CONV state); default is zero-suppressed decimal.
// TX handshake: tx_start pulses for one cycle with tx_data valid; tx_data holds
// until tx_done_tick, and the next tx_start comes no earlier than the cycle after it.
module bip_result_reporter
    import bip_report_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_CH   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_done_tick,
    input  logic [7:0]             rx_data,
    input  logic                   tx_done_tick,
    input  logic                   done,
    input  logic [N_CH*DATA_W-1:0] results,
    output logic                   run,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [3:0]             dbg_state
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
`ifdef REPORT_HEX_EN
    localparam int NIB_N = (DATA_W + 3) / 4;
`else
    localparam int DIG_N = dig_n(DATA_W);
    localparam int NIB_N = DIG_N;
`endif
    localparam int NIB_W = NIB_N * 4;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [3:0]        dig_q, dig_d;
    logic              latch_en;
    logic [DATA_W-1:0] shadow_q [N_CH];
    logic [NIB_W-1:0]  dig_vec;
    logic [3:0]        first_dig;
    logic [3:0]        cur_nib;
    logic              run_q, busy_q, tx_start_q;
    logic [7:0]        tx_data_q;
    logic              run_d, busy_d, tx_start_d;
    logic [7:0]        tx_data_d;

`ifdef REPORT_HEX_EN
    // Hex digits come straight from the shadow; always print every digit.
    assign dig_vec   = NIB_W'(shadow_q[ch_q]);
    assign first_dig = 4'(NIB_N - 1);
`else
    logic conv_start, conv_busy, conv_done;

    bip_bin2bcd #(.DATA_W(DATA_W)) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (conv_start),
        .bin_i   (shadow_q[ch_d]),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (dig_vec)
    );

    // Most significant nonzero digit; a zero value still sends its units digit.
    always_comb begin
        first_dig = 4'd0;
        for (int i = 0; i < NIB_N; i++) begin
            if (dig_vec[i*4 +: 4] != 4'd0) first_dig = 4'(i);
        end
    end
`endif

    // Nibble for the digit about to be transmitted.
    always_comb begin
        cur_nib = 4'd0;
        for (int i = 0; i < NIB_N; i++) begin
            if (4'(i) == dig_d) cur_nib = dig_vec[i*4 +: 4];
        end
    end

    // State register with channel and digit indices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dig_q   <= dig_d;
        end
    end

    // Next-state logic: command parser, run control and byte sequencing.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        dig_d    = dig_q;
        latch_en = 1'b0;
`ifndef REPORT_HEX_EN
        conv_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_done_tick && rx_data == CHAR_S) state_d = ST_GOT_S;
            end
            ST_GOT_S: begin
                if (rx_done_tick) begin
                    if (rx_data == CHAR_CR) begin
                        state_d = ST_RUN;
                        ch_d    = '0;
                    end else if (rx_data != CHAR_S) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (done) begin
                    state_d  = ST_LATCH;
                    latch_en = 1'b1;
                    ch_d     = '0;
                end
            end
            ST_LATCH: begin
`ifdef REPORT_HEX_EN
                state_d = ST_LABEL;
`else
                state_d    = ST_CONV;
                conv_start = 1'b1;
`endif
            end
            ST_CONV: begin
`ifndef REPORT_HEX_EN
                if (conv_done && !conv_busy) state_d = ST_LABEL;
`endif
            end
            ST_LABEL: begin
                if (tx_done_tick) state_d = ST_COLON;
            end
            ST_COLON: begin
                if (tx_done_tick) begin
                    state_d = ST_DIGIT;
                    dig_d   = first_dig;
                end
            end
            ST_DIGIT: begin
                if (tx_done_tick) begin
                    if (dig_q == 4'd0) state_d = ST_CR;
                    else               dig_d   = dig_q - 4'd1;
                end
            end
            ST_CR: begin
                if (tx_done_tick) state_d = ST_LF;
            end
            ST_LF: begin
                if (tx_done_tick) begin
                    if (ch_q == LAST_CH) begin
                        state_d = ST_IDLE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
`ifdef REPORT_HEX_EN
                        state_d = ST_LABEL;
`else
                        state_d    = ST_CONV;
                        conv_start = 1'b1;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: a byte is launched on entry to each byte state (and per digit).
    always_comb begin
        run_d      = (state_d == ST_RUN);
        busy_d     = !(state_d == ST_IDLE || state_d == ST_GOT_S);
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if (state_d != state_q || (state_q == ST_DIGIT && tx_done_tick)) begin
            case (state_d)
                ST_LABEL: begin tx_start_d = 1'b1; tx_data_d = CHAR_A + 8'(ch_d); end
                ST_COLON: begin tx_start_d = 1'b1; tx_data_d = CHAR_COLON;        end
                ST_DIGIT: begin tx_start_d = 1'b1; tx_data_d = nib_to_ascii(cur_nib); end
                ST_CR:    begin tx_start_d = 1'b1; tx_data_d = CHAR_CR;           end
                ST_LF:    begin tx_start_d = 1'b1; tx_data_d = CHAR_LF;           end
                default:  ;
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            run_q      <= run_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Shadow copy of all channels, taken when done is first seen in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
        end else if (latch_en) begin
            for (int i = 0; i < N_CH; i++) shadow_q[i] <= results[i*DATA_W +: DATA_W];
        end
    end

    assign run       = run_q;
    assign busy      = busy_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bip_result_reporter.sv
// Bench for bip_result_reporter: a 16-bit/2-channel and a 32-bit/3-channel instance.
module tb_bip_result_reporter;
    import bip_report_pkg::*;

    localparam int WA = 16, NA = 2, WB = 32, NB = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             rx_tick_a = 0, tx_done_a = 0, done_a = 0;
    logic [7:0]       rx_data_a = 0;
    logic [NA*WA-1:0] results_a = '0;
    logic             run_a, tx_start_a, busy_a;
    logic [7:0]       tx_data_a;
    logic [3:0]       dbg_a;

    logic             rx_tick_b = 0, tx_done_b = 0, done_b = 0;
    logic [7:0]       rx_data_b = 0;
    logic [NB*WB-1:0] results_b = '0;
    logic             run_b, tx_start_b, busy_b;
    logic [7:0]       tx_data_b;
    logic [3:0]       dbg_b;

    bip_result_reporter #(.DATA_W(WA), .N_CH(NA)) u_dut_a (
        .clk(clk), .reset(reset), .rx_done_tick(rx_tick_a), .rx_data(rx_data_a),
        .tx_done_tick(tx_done_a), .done(done_a), .results(results_a), .run(run_a),
        .tx_start(tx_start_a), .tx_data(tx_data_a), .busy(busy_a), .dbg_state(dbg_a));

    bip_result_reporter #(.DATA_W(WB), .N_CH(NB)) u_dut_b (
        .clk(clk), .reset(reset), .rx_done_tick(rx_tick_b), .rx_data(rx_data_b),
        .tx_done_tick(tx_done_b), .done(done_b), .results(results_b), .run(run_b),
        .tx_start(tx_start_b), .tx_data(tx_data_b), .busy(busy_b), .dbg_state(dbg_b));

    // ---------------- scoreboard ----------------
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic string pick(input string dec_s, input string hex_s);
`ifdef REPORT_HEX_EN
        return hex_s;
`else
        return dec_s;
`endif
    endfunction

    function automatic logic get_start(input int which);
        return (which == 0) ? tx_start_a : tx_start_b;
    endfunction
    function automatic logic [7:0] get_data(input int which);
        return (which == 0) ? tx_data_a : tx_data_b;
    endfunction
    function automatic logic get_run(input int which);
        return (which == 0) ? run_a : run_b;
    endfunction
    function automatic logic get_busy(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic [3:0] get_dbg(input int which);
        return (which == 0) ? dbg_a : dbg_b;
    endfunction
    function automatic int qsize(input int which);
        return (which == 0) ? exp_a.size() : exp_b.size();
    endfunction

    task automatic push_str(input int which, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (which == 0) exp_a.push_back(s[i]);
            else            exp_b.push_back(s[i]);
        end
    endtask

    task automatic push_line(input int which, input string s);
        push_str(which, s);
        if (which == 0) begin exp_a.push_back(CHAR_CR); exp_a.push_back(CHAR_LF); end
        else            begin exp_b.push_back(CHAR_CR); exp_b.push_back(CHAR_LF); end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_rx(input int which, input logic [7:0] b);
        @(negedge clk);
        if (which == 0) begin rx_data_a = b; rx_tick_a = 1'b1; end
        else            begin rx_data_b = b; rx_tick_b = 1'b1; end
        @(negedge clk);
        rx_tick_a = 1'b0;
        rx_tick_b = 1'b0;
    endtask

    task automatic start_cmd(input int which);
        send_rx(which, CHAR_S);
        send_rx(which, CHAR_CR);
        check($sformatf("run_rise[%0d]", which), 32'(get_run(which)), 32'd1);
        check($sformatf("busy_rise[%0d]", which), 32'(get_busy(which)), 32'd1);
    endtask

    task automatic finish_prog(input int which);
        @(negedge clk);
        if (which == 0) done_a = 1'b1; else done_b = 1'b1;
        @(negedge clk);
        check($sformatf("run_fall[%0d]", which), 32'(get_run(which)), 32'd0);
        done_a = 1'b0;
        done_b = 1'b0;
    endtask

    task automatic wait_idle(input int which);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!get_busy(which) && qsize(which) == 0) break;
        end
        check($sformatf("report_end_busy[%0d]", which), 32'(get_busy(which)), 32'd0);
        check($sformatf("report_bytes_left[%0d]", which), 32'(qsize(which)), 32'd0);
    endtask

    task automatic set_done_tick(input int which, input logic v);
        if (which == 0) tx_done_a = v; else tx_done_b = v;
    endtask

    // UART TX model and byte monitor: pops the expected queue per launched byte.
    task automatic tx_responder(input int which);
        logic [7:0] cap, exp;
        logic       extra;
        int         gap;
        forever begin
            @(negedge clk);
            while (get_start(which)) begin
                cap = get_data(which);
                if (qsize(which) == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_byte[%0d]: got %02h, expected no byte", which, cap);
                end else begin
                    if (which == 0) exp = exp_a.pop_front();
                    else            exp = exp_b.pop_front();
                    check($sformatf("tx_byte[%0d]", which), 32'(cap), 32'(exp));
                end
                gap   = $urandom_range(1, 3);
                extra = 1'b0;
                repeat (gap) begin
                    @(negedge clk);
                    if (get_start(which)) extra = 1'b1;
                end
                if (!reset) begin
                    check($sformatf("tx_data_hold[%0d]", which), 32'(get_data(which)), 32'(cap));
                    check($sformatf("tx_start_early[%0d]", which), 32'(extra), 32'd0);
                end
                set_done_tick(which, 1'b1);
                @(negedge clk);
                set_done_tick(which, 1'b0);
            end
        end
    endtask

    // Length of each CONV run must equal the channel width.
    task automatic conv_watch(input int which, input int width);
        int n = 0;
        forever begin
            @(negedge clk);
            if (get_dbg(which) == ST_CONV) n++;
            else if (n != 0) begin
                check($sformatf("conv_cycles[%0d]", which), 32'(n), 32'(width));
                n = 0;
            end
        end
    endtask

    initial tx_responder(0);
    initial tx_responder(1);
    initial conv_watch(0, WA);
    initial conv_watch(1, WB);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_run", 32'(run_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_tx_start", 32'(tx_start_a), 32'd0);
        check("rst_tx_data", 32'(tx_data_a), 32'd0);
        check("rst_state", 32'(dbg_a), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // Basic report, including a zero value.
        results_a = {16'h0000, 16'h00FF};
        push_line(0, pick("A:255", "A:00FF"));
        push_line(0, pick("B:0", "B:0000"));
        start_cmd(0);
        finish_prog(0);
        wait_idle(0);

        // Malformed commands, then a repeated 's' before CR.
        send_rx(0, 8'h78);
        send_rx(0, CHAR_CR);
        check("bad_cmd_x", 32'(run_a), 32'd0);
        send_rx(0, CHAR_S);
        send_rx(0, 8'h71);
        send_rx(0, CHAR_CR);
        check("bad_cmd_sq", 32'(run_a), 32'd0);
        results_a = {16'd12345, 16'd171};
        push_line(0, pick("A:171", "A:00AB"));
        push_line(0, pick("B:12345", "B:3039"));
        send_rx(0, CHAR_S);
        start_cmd(0);
        finish_prog(0);
        wait_idle(0);

        // Results change after latch; a command during the report is dropped.
        results_a = {16'd65535, 16'd1000};
        push_line(0, pick("A:1000", "A:03E8"));
        push_line(0, pick("B:65535", "B:FFFF"));
        start_cmd(0);
        finish_prog(0);
        results_a = {16'h1234, 16'h5678};
        send_rx(0, CHAR_S);
        check("mid_report_s", 32'(run_a), 32'd0);
        send_rx(0, CHAR_CR);
        check("mid_report_cr", 32'(run_a), 32'd0);
        check("mid_report_busy", 32'(busy_a), 32'd1);
        wait_idle(0);
        check("post_report_run", 32'(run_a), 32'd0);
        send_rx(0, CHAR_CR);
        check("parser_restarted", 32'(run_a), 32'd0);

        // Wide instance, three channels.
        results_b = {32'd1000000000, 32'd10, 32'hFFFFFFFF};
        push_line(1, pick("A:4294967295", "A:FFFFFFFF"));
        push_line(1, pick("B:10", "B:0000000A"));
        push_line(1, pick("C:1000000000", "C:3B9ACA00"));
        start_cmd(1);
        finish_prog(1);
        wait_idle(1);

        // Reset while channel B digits are being sent.
        results_a = {16'd54321, 16'd5};
        push_line(0, pick("A:5", "A:0005"));
        push_str(0, pick("B:5", "B:D"));
        start_cmd(0);
        finish_prog(0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_a.size() == 0) break;
        end
        check("pre_reset_queue", 32'(exp_a.size()), 32'd0);
        check("pre_reset_state", 32'(dbg_a), 32'(ST_DIGIT));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_start", 32'(tx_start_a), 32'd0);
        check("mid_rst_run", 32'(run_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data_a), 32'd0);
        check("mid_rst_state", 32'(dbg_a), 32'(ST_IDLE));
        repeat (4) @(negedge clk);
        reset = 1'b0;

        // Fresh command after reset.
        results_a = {16'd100, 16'd0};
        push_line(0, pick("A:0", "A:0000"));
        push_line(0, pick("B:100", "B:0064"));
        start_cmd(0);
        finish_prog(0);
        wait_idle(0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
